// File: rtl/approx_mul_rr_scheduler.sv
// ---------------------------------------------------------------------------
// approx_mul_rr_scheduler
//
// Shares one external combinational 8x8 approximate multiplier among N_REQ
// requesters. A round-robin arbiter picks one requester per cycle. The
// winning operands are registered in stage S1, which drives the multiplier
// inputs. The product is registered in stage S2 and returned with the
// requester ID over a valid/ready response port.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid[N_REQ]    per-requester operand valid
//   req_x/req_y         per-requester operands, requester i at [8i+7:8i]
//   req_ready[N_REQ]    one-hot grant (zero when nothing is accepted)
//   mul_x/mul_y         operands to the shared multiplier (registered)
//   mul_z               product from the shared multiplier
//   resp_valid/ready    response handshake
//   resp_z, resp_id     registered product and the ID of its requester
//   busy                either pipeline stage holds a transaction
// ---------------------------------------------------------------------------
module approx_mul_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_x,
    input  logic [8*N_REQ-1:0]   req_y,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           mul_x,
    output logic [7:0]           mul_y,
    input  logic [15:0]          mul_z,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [15:0]          resp_z,
    output logic [ID_W-1:0]      resp_id,
    output logic                 busy
);

    localparam int NEED_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

    // The ID field must be exactly wide enough to name every requester.
    if (ID_W != NEED_W) begin : g_bad_id_w
        $fatal(1, "approx_mul_rr_scheduler: ID_W does not match N_REQ");
    end

    logic            s1_vld_q;
    logic [7:0]      s1_x_q;
    logic [7:0]      s1_y_q;
    logic [ID_W-1:0] s1_id_q;
    logic            s2_vld_q;
    logic [15:0]     s2_z_q;
    logic [ID_W-1:0] s2_id_q;
    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] rr_ptr_d;

    logic            s2_free;
    logic            s1_adv;
    logic            s1_free;
    logic            gnt_found;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_any;

    assign s2_free = !s2_vld_q || resp_ready;
    assign s1_adv  = s1_vld_q && s2_free;
    assign s1_free = !s1_vld_q || s1_adv;

    // Rotating priority scan starting at rr_ptr. Only req_valid feeds this,
    // so the grant never depends on operand values.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = ID_W'(idx);
            end
        end
    end

    // Reset is folded in so the grant reads zero while reset is asserted.
    assign gnt_any = gnt_found && s1_free && rst_n;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = gnt_any && (gnt_id == ID_W'(i));
        end
    end

    // The pointer moves to the requester just after the winner.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any) begin
            rr_ptr_d = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    // S1: operand register. Operands only change on a grant, so the
    // multiplier inputs stay quiet while S1 holds or sits empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_x_q   <= '0;
            s1_y_q   <= '0;
            s1_id_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (gnt_any) begin
                s1_vld_q <= 1'b1;
                s1_x_q   <= req_x[8*gnt_id +: 8];
                s1_y_q   <= req_y[8*gnt_id +: 8];
                s1_id_q  <= gnt_id;
            end else if (s1_adv) begin
                s1_vld_q <= 1'b0;
            end
        end
    end

    // S2: result register. A load on s1_adv wins over a simultaneous
    // response fire so back-to-back results flow at one per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q <= 1'b0;
            s2_z_q   <= '0;
            s2_id_q  <= '0;
        end else begin
            if (s1_adv) begin
                s2_vld_q <= 1'b1;
                s2_z_q   <= mul_z;
                s2_id_q  <= s1_id_q;
            end else if (resp_ready) begin
                s2_vld_q <= 1'b0;
            end
        end
    end

    assign mul_x      = s1_x_q;
    assign mul_y      = s1_y_q;
    assign resp_valid = s2_vld_q;
    assign resp_z     = s2_z_q;
    assign resp_id    = s2_id_q;
    assign busy       = s1_vld_q || s2_vld_q;

endmodule

// File: tb/tb_approx_mul_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_approx_mul_rr_scheduler
//
// Bench for approx_mul_rr_scheduler with an exact multiplier stub. The
// reference model treats the block as an ordered two-deep pipeline: a
// result becomes visible two edges after acceptance, a new request can be
// taken whenever fewer than two results remain after this cycle's fire, and
// the grant is the first valid requester scanning from the pointer.
// ---------------------------------------------------------------------------
module tb_approx_mul_rr_scheduler;

    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [8*N-1:0]  req_x;
    logic [8*N-1:0]  req_y;
    logic [N-1:0]    req_ready;
    logic [7:0]      mul_x;
    logic [7:0]      mul_y;
    logic [15:0]     mul_z;
    logic            resp_valid;
    logic            resp_ready;
    logic [15:0]     resp_z;
    logic [IW-1:0]   resp_id;
    logic            busy;

    approx_mul_rr_scheduler #(.N_REQ(N), .ID_W(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_ready  (req_ready),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_z      (mul_z),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_z     (resp_z),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    // Exact product stands in for the approximate multiplier.
    assign mul_z = 16'(mul_x) * 16'(mul_y);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int id;
        int z;
        int stamp;
    } item_t;

    item_t pipeQ[$];
    int    ptr;
    int    cyc;
    int    compared;
    int    mismatched;

    int          lastGnt;
    logic [N-1:0] lastReady;
    logic [7:0]  lastMulX;
    logic [15:0] lastRespZ;
    logic [IW-1:0] lastRespId;
    logic        lastRespValid;

    logic        pendV[N];
    logic [7:0]  pendX[N];
    logic [7:0]  pendY[N];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        pipeQ.delete();
        ptr = 0;
    endtask

    // One full cycle: drive at the falling edge, check the settled outputs
    // against the model, then retire/accept in the model at the rising edge.
    task automatic applyStimulus(input logic [N-1:0] v, input logic [8*N-1:0] xs,
                                 input logic [8*N-1:0] ys, input logic rr);
        bit visible;
        bit fire;
        bit canAccept;
        int gnt;
        logic [N-1:0] expReady;
        @(negedge clk);
        req_valid  = v;
        req_x      = xs;
        req_y      = ys;
        resp_ready = rr;
        #1;
        visible   = (pipeQ.size() > 0) && (pipeQ[0].stamp + 2 <= cyc);
        fire      = visible && rr;
        canAccept = (pipeQ.size() - (fire ? 1 : 0)) < 2;
        gnt = -1;
        if (canAccept) begin
            for (int k = 0; k < N; k++) begin
                if (gnt < 0 && v[(ptr + k) % N]) begin
                    gnt = (ptr + k) % N;
                end
            end
        end
        expReady = '0;
        if (gnt >= 0) expReady[gnt] = 1'b1;
        checkOutput("req_ready", 32'(req_ready), 32'(expReady));
        checkOutput("resp_valid", 32'(resp_valid), 32'(visible));
        if (visible) begin
            checkOutput("resp_z", 32'(resp_z), 32'(pipeQ[0].z));
            checkOutput("resp_id", 32'(resp_id), 32'(pipeQ[0].id));
        end
        checkOutput("busy", 32'(busy), 32'(pipeQ.size() != 0));
        lastGnt       = gnt;
        lastReady     = req_ready;
        lastMulX      = mul_x;
        lastRespZ     = resp_z;
        lastRespId    = resp_id;
        lastRespValid = resp_valid;
        @(posedge clk);
        if (fire) void'(pipeQ.pop_front());
        if (gnt >= 0) begin
            item_t it;
            it.id    = gnt;
            it.z     = int'(xs[8*gnt +: 8]) * int'(ys[8*gnt +: 8]);
            it.stamp = cyc;
            pipeQ.push_back(it);
            ptr = (gnt + 1) % N;
        end
        cyc++;
    endtask

    task automatic drain(input int n);
        repeat (n) applyStimulus('0, '0, '0, 1'b1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req_ready"}, 32'(req_ready), 0);
        checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_mul_x"}, 32'(mul_x), 0);
        checkOutput({tag, "_mul_y"}, 32'(mul_y), 0);
        checkOutput({tag, "_resp_z"}, 32'(resp_z), 0);
        checkOutput({tag, "_resp_id"}, 32'(resp_id), 0);
    endtask

    initial begin
        logic [8*N-1:0] xs;
        logic [8*N-1:0] ys;
        logic [N-1:0]   v;
        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        req_valid  = '0;
        req_x      = '0;
        req_y      = '0;
        resp_ready = 1'b0;
        rst_n      = 1'b1;
        modelReset();

        // Asynchronous reset mid-cycle, then idle after release.
        #3 rst_n = 1'b0;
        #1 checkAllZero("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        drain(2);
        checkOutput("idle_ready", 32'(lastReady), 0);

        // Round-robin with everyone requesting: 0,1,2,3,0,...
        for (int k = 0; k < 8; k++) begin
            xs = {$urandom, $urandom} ;
            ys = {$urandom, $urandom} ;
            applyStimulus(4'hF, xs, ys, 1'b1);
            checkOutput("rr_order", 32'(lastReady), 32'(1 << (k % 4)));
        end
        drain(3);

        // Single operation from requester 2.
        xs = 32'd200 << 16;
        ys = 32'd150 << 16;
        applyStimulus(4'b0100, xs, ys, 1'b1);
        checkOutput("single_gnt", 32'(lastReady), 32'b0100);
        applyStimulus('0, '0, '0, 1'b1);
        checkOutput("single_early", 32'(lastRespValid), 0);
        applyStimulus('0, '0, '0, 1'b1);
        checkOutput("single_valid", 32'(lastRespValid), 1);
        checkOutput("single_z", 32'(lastRespZ), 30000);
        checkOutput("single_id", 32'(lastRespId), 2);
        drain(2);

        // Pointer wrap: pointer is now 3; requesters 0 and 3 compete.
        xs = 32'h0a0b0c0d;
        ys = 32'h01020304;
        applyStimulus(4'b1001, xs, ys, 1'b1);
        checkOutput("wrap_first", 32'(lastReady), 32'b1000);
        applyStimulus(4'b0001, xs, ys, 1'b1);
        checkOutput("wrap_second", 32'(lastReady), 32'b0001);
        applyStimulus(4'b0010, xs, ys, 1'b1);
        checkOutput("wrap_lone", 32'(lastReady), 32'b0010);
        drain(3);

        // Backpressure: (3,5) then (255,255), consumer stalled.
        xs = {8'd0, 8'd7, 8'd255, 8'd3};
        ys = {8'd0, 8'd9, 8'd255, 8'd5};
        applyStimulus(4'b0001, xs, ys, 1'b0);
        checkOutput("bp_gnt0", 32'(lastReady), 32'b0001);
        applyStimulus(4'b0010, xs, ys, 1'b0);
        checkOutput("bp_gnt1", 32'(lastReady), 32'b0010);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b0100, xs, ys, 1'b0);
            checkOutput("bp_ready", 32'(lastReady), 0);
            checkOutput("bp_mul_x", 32'(lastMulX), 255);
            checkOutput("bp_hold_z", 32'(lastRespZ), 15);
        end
        applyStimulus(4'b0100, xs, ys, 1'b1);
        checkOutput("bp_rel_z0", 32'(lastRespZ), 15);
        applyStimulus('0, xs, ys, 1'b1);
        checkOutput("bp_rel_z1", 32'(lastRespZ), 65025);
        checkOutput("bp_rel_v1", 32'(lastRespValid), 1);
        drain(3);

        // Randomized traffic; operands are held until each request is taken.
        for (int i = 0; i < N; i++) pendV[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pendV[i] && ($urandom_range(0, 1) == 1)) begin
                    pendV[i] = 1'b1;
                    pendX[i] = 8'($urandom);
                    pendY[i] = 8'($urandom);
                end
                v[i]          = pendV[i];
                xs[8*i +: 8]  = pendX[i];
                ys[8*i +: 8]  = pendY[i];
            end
            applyStimulus(v, xs, ys, ($urandom_range(0, 3) != 0));
            if (lastGnt >= 0) pendV[lastGnt] = 1'b0;
        end
        drain(4);

        // Reset with two operations in flight drops both.
        applyStimulus(4'b0001, 32'd10, 32'd11, 1'b0);
        applyStimulus(4'b0010, 32'd12 << 8, 32'd13 << 8, 1'b0);
        #2 rst_n = 1'b0;
        #1 checkAllZero("rst_flight");
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        drain(3);
        checkOutput("post_rst_valid", 32'(lastRespValid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
